// File: rtl/viterbi_ber_monitor_if.sv
// Bus bundle for viterbi_ber_monitor: reference/decoded bit streams, clear, and statistics.
// Window outputs exist only when VITERBI_BER_WINDOW_EN is defined.
interface viterbi_ber_monitor_if #(
    parameter int CNT_W = 16
);
    logic             clear_i;
    logic             ref_valid_i;
    logic             ref_bit_i;
    logic             dec_valid_i;
    logic             dec_bit_i;
    logic [CNT_W-1:0] bit_count_o;
    logic [CNT_W-1:0] err_count_o;
    logic [CNT_W-1:0] burst_count_o;
    logic [CNT_W-1:0] max_burst_o;
    logic             locked_o;
    logic             lost_o;
    logic             ovf_o;
    logic             unf_o;
`ifdef VITERBI_BER_WINDOW_EN
    logic [CNT_W-1:0] win_err_o;
    logic             win_valid_o;
`endif

    modport master (
        output clear_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i,
        input  bit_count_o, err_count_o, burst_count_o, max_burst_o,
        input  locked_o, lost_o, ovf_o, unf_o
`ifdef VITERBI_BER_WINDOW_EN
        , input win_err_o, win_valid_o
`endif
    );

    modport slave (
        input  clear_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i,
        output bit_count_o, err_count_o, burst_count_o, max_burst_o,
        output locked_o, lost_o, ovf_o, unf_o
`ifdef VITERBI_BER_WINDOW_EN
        , output win_err_o, win_valid_o
`endif
    );
endinterface

// File: rtl/viterbi_ber_monitor.sv
// Viterbi receive-side BER monitor: reference FIFO, 1-cycle compare, saturating stats, sync FSM.
// Optional per-window error count is enabled with VITERBI_BER_WINDOW_EN.
module viterbi_ber_monitor #(
    parameter int DEPTH       = 64,
    parameter int CNT_W       = 16,
    parameter int LOSS_THRESH = 8,
    parameter int WINDOW      = 256
) (
    input logic                 clk,
    input logic                 rst,
    viterbi_ber_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] LOST  = 2'd2;
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(LOSS_THRESH);

    if (DEPTH != (1 << AW) || WINDOW < 1 || LOSS_THRESH < 1) begin : g_bad_param
        $error("viterbi_ber_monitor: illegal parameter value");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, pop, push;

    logic             cmp_vld, cmp_err;
    logic [CNT_W-1:0] bit_cnt, err_cnt, burst_cnt, max_burst;
    logic [CNT_W-1:0] run, good;
    logic [CNT_W-1:0] run_inc, good_inc;
    logic [1:0]       state;
    logic             lost, ovf, unf;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = bus.dec_valid_i && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push  = bus.ref_valid_i && (!full || pop);

    assign run_inc  = sat_inc(run);
    assign good_inc = sat_inc(good);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= bus.ref_bit_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmp_vld   <= 1'b0;
            cmp_err   <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            burst_cnt <= '0;
            max_burst <= '0;
            run       <= '0;
            good      <= '0;
            state     <= IDLE;
            lost      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (bus.clear_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmp_vld   <= 1'b0;
            cmp_err   <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            burst_cnt <= '0;
            max_burst <= '0;
            run       <= '0;
            good      <= '0;
            state     <= IDLE;
            lost      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (bus.ref_valid_i && full && !pop)
                ovf <= 1'b1;
            if (bus.dec_valid_i && empty)
                unf <= 1'b1;

            cmp_vld <= pop;
            cmp_err <= mem[rd_ptr[AW-1:0]] ^ bus.dec_bit_i;

            if (cmp_vld) begin
                bit_cnt <= sat_inc(bit_cnt);
                if (cmp_err) begin
                    err_cnt <= sat_inc(err_cnt);
                    run     <= run_inc;
                    good    <= '0;
                    if (run == '0)
                        burst_cnt <= sat_inc(burst_cnt);
                    if (run_inc > max_burst)
                        max_burst <= run_inc;
                end else begin
                    run  <= '0;
                    good <= good_inc;
                end

                unique case (state)
                    IDLE: state <= TRACK;
                    TRACK: begin
                        if (cmp_err && run_inc >= THRESH) begin
                            state <= LOST;
                            lost  <= 1'b1;
                        end
                    end
                    LOST: begin
                        if (!cmp_err && good_inc >= THRESH)
                            state <= TRACK;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.bit_count_o   = bit_cnt;
    assign bus.err_count_o   = err_cnt;
    assign bus.burst_count_o = burst_cnt;
    assign bus.max_burst_o   = max_burst;
    assign bus.locked_o      = (state == TRACK);
    assign bus.lost_o        = lost;
    assign bus.ovf_o         = ovf;
    assign bus.unf_o         = unf;

`ifdef VITERBI_BER_WINDOW_EN
    localparam int WW = $clog2(WINDOW) + 1;

    logic [WW-1:0]    win_cnt;
    logic [CNT_W-1:0] win_acc, win_acc_nxt, win_err;
    logic             win_valid;

    assign win_acc_nxt = cmp_err ? sat_inc(win_acc) : win_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt   <= '0;
            win_acc   <= '0;
            win_err   <= '0;
            win_valid <= 1'b0;
        end else if (bus.clear_i) begin
            win_cnt   <= '0;
            win_acc   <= '0;
            win_err   <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (cmp_vld) begin
                if (win_cnt == WW'(WINDOW - 1)) begin
                    win_err   <= win_acc_nxt;
                    win_valid <= 1'b1;
                    win_cnt   <= '0;
                    win_acc   <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    win_acc <= win_acc_nxt;
                end
            end
        end
    end

    assign bus.win_err_o   = win_err;
    assign bus.win_valid_o = win_valid;
`endif
endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Directed self-checking bench for viterbi_ber_monitor (DEPTH=64, LOSS_THRESH=8).
// Window checks compile in only when VITERBI_BER_WINDOW_EN is defined.
module tb_viterbi_ber_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_fail = 0;
    logic [511:0] mask = '0;

    viterbi_ber_monitor_if #(.CNT_W(16)) bus ();

    viterbi_ber_monitor #(
        .DEPTH(64), .CNT_W(16), .LOSS_THRESH(8), .WINDOW(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic pat(input int i);
        return i[0] ^ i[3] ^ (i % 3 == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.clear_i     = 1'b0;
        bus.ref_valid_i = 1'b0;
        bus.ref_bit_i   = 1'b0;
        bus.dec_valid_i = 1'b0;
        bus.dec_bit_i   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        idle();
        tick();
        tick();
    endtask

    task automatic do_clear();
        idle();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    task automatic stream(input int n, input int lag, input int base);
        for (int c = 0; c < n + lag; c++) begin
            bus.ref_valid_i = (c < n);
            bus.ref_bit_i   = (c < n) ? pat(base + c) : 1'b0;
            bus.dec_valid_i = (c >= lag);
            bus.dec_bit_i   = (c >= lag) ? pat(base + c - lag) ^ mask[c - lag] : 1'b0;
            tick();
        end
        settle();
    endtask

    task automatic push_n(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            idle();
            bus.ref_valid_i = 1'b1;
            bus.ref_bit_i   = pat(base + k);
            tick();
        end
        idle();
    endtask

    task automatic pop_n(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            idle();
            bus.dec_valid_i = 1'b1;
            bus.dec_bit_i   = pat(base + k);
            tick();
        end
        settle();
    endtask

`ifdef VITERBI_BER_WINDOW_EN
    int pulses = 0;
    logic [15:0] win_log [0:3];
    always @(posedge clk) begin
        #1;
        if (bus.win_valid_o) begin
            if (pulses < 4)
                win_log[pulses] = bus.win_err_o;
            pulses++;
        end
    end
`endif

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_bit", 32'(bus.bit_count_o), 0);
        chk("rst_err", 32'(bus.err_count_o), 0);
        chk("rst_burst", 32'(bus.burst_count_o), 0);
        chk("rst_max", 32'(bus.max_burst_o), 0);
        chk("rst_locked", 32'(bus.locked_o), 0);
        chk("rst_lost", 32'(bus.lost_o), 0);
        chk("rst_ovf", 32'(bus.ovf_o), 0);
        chk("rst_unf", 32'(bus.unf_o), 0);
        rst = 1'b0;
        tick();

        mask = '0;
        stream(100, 40, 0);
        chk("t1_bit", 32'(bus.bit_count_o), 100);
        chk("t1_err", 32'(bus.err_count_o), 0);
        chk("t1_burst", 32'(bus.burst_count_o), 0);
        chk("t1_locked", 32'(bus.locked_o), 1);
        chk("t1_unf", 32'(bus.unf_o), 0);

        do_clear();
        chk("clr_bit", 32'(bus.bit_count_o), 0);
        chk("clr_locked", 32'(bus.locked_o), 0);
        mask = '0;
        mask[10] = 1'b1;
        mask[11] = 1'b1;
        mask[12] = 1'b1;
        mask[50] = 1'b1;
        stream(100, 40, 0);
        chk("t2_bit", 32'(bus.bit_count_o), 100);
        chk("t2_err", 32'(bus.err_count_o), 4);
        chk("t2_burst", 32'(bus.burst_count_o), 2);
        chk("t2_max", 32'(bus.max_burst_o), 3);
        chk("t2_lost", 32'(bus.lost_o), 0);
        chk("t2_locked", 32'(bus.locked_o), 1);

        do_clear();
        mask = '0;
        for (int k = 5; k <= 12; k++)
            mask[k] = 1'b1;
        stream(13, 3, 0);
        chk("t3_err", 32'(bus.err_count_o), 8);
        chk("t3_max", 32'(bus.max_burst_o), 8);
        chk("t3_burst", 32'(bus.burst_count_o), 1);
        chk("t3_lost", 32'(bus.lost_o), 1);
        chk("t3_unlocked", 32'(bus.locked_o), 0);
        mask = '0;
        stream(7, 3, 100);
        chk("t3_still_lost", 32'(bus.locked_o), 0);
        stream(1, 1, 107);
        chk("t3_relock", 32'(bus.locked_o), 1);
        chk("t3_lost_sticky", 32'(bus.lost_o), 1);
        chk("t3_bit", 32'(bus.bit_count_o), 21);

        do_clear();
        push_n(64, 0);
        tick();
        chk("t4_no_ovf_64", 32'(bus.ovf_o), 0);
        bus.ref_valid_i = 1'b1;
        bus.ref_bit_i   = pat(64);
        bus.dec_valid_i = 1'b1;
        bus.dec_bit_i   = pat(0);
        tick();
        idle();
        chk("t4_full_pushpop", 32'(bus.ovf_o), 0);
        pop_n(64, 1);
        chk("t4_pp_bit", 32'(bus.bit_count_o), 65);
        chk("t4_pp_err", 32'(bus.err_count_o), 0);
        chk("t4_pp_unf", 32'(bus.unf_o), 0);
        bus.dec_valid_i = 1'b1;
        bus.dec_bit_i   = 1'b0;
        bus.ref_valid_i = 1'b1;
        bus.ref_bit_i   = 1'b0;
        tick();
        idle();
        chk("t5_unf", 32'(bus.unf_o), 1);
        settle();
        chk("t5_bit_hold", 32'(bus.bit_count_o), 65);

        do_clear();
        push_n(64, 0);
        chk("t4_ovf_pre", 32'(bus.ovf_o), 0);
        push_n(1, 64);
        chk("t4_ovf", 32'(bus.ovf_o), 1);
        pop_n(64, 0);
        chk("t4_drain_bit", 32'(bus.bit_count_o), 64);
        chk("t4_drain_err", 32'(bus.err_count_o), 0);
        chk("t4_drain_unf", 32'(bus.unf_o), 0);

        bus.ref_valid_i = 1'b1;
        bus.dec_valid_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_bit", 32'(bus.bit_count_o), 0);
        chk("t5_rst_ovf", 32'(bus.ovf_o), 0);
        chk("t5_rst_lost", 32'(bus.lost_o), 0);
        idle();
        tick();
        rst = 1'b0;
        tick();

`ifdef VITERBI_BER_WINDOW_EN
        do_clear();
        chk("t6_win_rst", 32'(bus.win_err_o), 0);
        mask = '0;
        mask[7]   = 1'b1;
        mask[100] = 1'b1;
        mask[200] = 1'b1;
        stream(512, 4, 0);
        tick();
        chk("t6_pulses", 32'(pulses), 2);
        chk("t6_win0", 32'(win_log[0]), 3);
        chk("t6_win1", 32'(win_log[1]), 0);
        chk("t6_err", 32'(bus.err_count_o), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
